nrisc_seq_ctrl: RTL
===================

NRISC_SEQ_CTRL -- requirements
Module: nrisc_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named Clock and Reset_n as the codebase does.
REQ-002 Ports SHALL be, clock and reset first:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  leave IDLE and begin fetching.
- OpcodeIn  in  3  memory read data [7:5], sampled at fetch ack.
- Zero  in  1  ULA zero flag.
- MemAck  in  1  memory access complete.
- MemReq  out  1  memory access request.
- SelEndMem  out  1  memory address source: 0=PC, 1=ULA result.
- LerMem, EscMem  out  1 each  memory read / write strobes.
- EscIR  out  1  load instruction register.
- EscPC, Branch, Jump  out  1 each  PC update and PC mux select.
- EscReg, MemToReg, MoveReg, RegDest, ULAFonte  out  1 each  datapath selects.
- ULAOp  out  2  00=add, 01=sub.
- Busy  out  1  high in every state except IDLE and HALTED.
- Halted  out  1  HALTED state indicator.
- Erro  out  1  watchdog fault, sticky.
- InstrCount  out  8  retired-instruction counter.

Function
REQ-003 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALTED, held in a registered state machine.
REQ-004 Opcodes SHALL be: 000 ADD, 001 SUB, 010 LW, 011 SW, 100 BEQ, 101 JR, 110 MOVE, 111 HALT.
REQ-005 IDLE SHALL go to FETCH on the edge where Start=1; otherwise it stays in IDLE.
REQ-006 FETCH SHALL drive MemReq=1, LerMem=1, SelEndMem=0 and wait; on the edge with MemAck=1 it latches OpcodeIn, pulses EscIR=1 and EscPC=1 (PC+1), and goes to DECODE.
REQ-007 DECODE SHALL last one cycle with no strobes; HALT goes to HALTED and MOVE goes to WB, all others to EXEC.
REQ-008 EXEC SHALL behave per opcode:
- ADD: ULAOp=00, then WB.
- SUB: ULAOp=01, then WB.
- LW/SW: ULAFonte=1, ULAOp=00, then MEM.
- BEQ: ULAOp=01, Branch=1, EscPC=Zero, then FETCH.
- JR: Jump=1, EscPC=1, then FETCH.
REQ-009 MEM SHALL drive MemReq=1 and SelEndMem=1, with LerMem=1 for LW or EscMem=1 for SW; on MemAck, LW goes to WB and SW goes to FETCH.
REQ-010 WB SHALL pulse EscReg=1 for one cycle, with MemToReg=1 for LW, MoveReg=1 for MOVE and RegDest=1 for LW, then go to FETCH.
REQ-011 Handshake rules:
- MemReq, SelEndMem and the read/write strobe SHALL stay stable until MemAck is sampled high.
- MemReq SHALL drop in the cycle after the ack.
- MemAck while MemReq=0 SHALL be ignored.
REQ-012 Cycle counts with zero-wait ack SHALL be: ADD/SUB/SW 4, LW 5, BEQ/JR/MOVE 3; each memory wait cycle adds 1.
REQ-013 InstrCount SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and on entry to HALTED; it wraps 255 to 0.
REQ-014 HALTED SHALL be absorbing, with all strobes 0 and Halted=1; Start is ignored there.
REQ-015 Every strobe not listed for a state SHALL be 0 in that state.

Reset
REQ-016 Reset_n=0 SHALL asynchronously force state IDLE, the opcode latch to 000, InstrCount=0, Halted=0, Erro=0 and every output strobe to 0, including mid-access; a pending MemAck is then ignored.

Configuration
REQ-017 With NRISC_SEQ_WATCHDOG_EN defined:
- A 4-bit counter SHALL count cycles in FETCH or MEM with MemReq=1 and MemAck=0, clearing on ack.
- On reaching 15 the block SHALL set Erro=1 and go to HALTED.
REQ-018 With NRISC_SEQ_WATCHDOG_EN undefined, no counter SHALL exist, Erro SHALL be tied to 0, and the wait is unbounded.

Structure
REQ-019 Package nrisc_pkg SHALL hold the opcode constants, ULAOp codes, state encoding and watchdog limit (15).
REQ-020 Sub-module nrisc_mem_hs SHALL hold the request/ack hold logic and the optional watchdog counter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then Start=1 with ADD (000) and ack in the same cycle -> 4 cycles; EscReg pulse in cycle 4; InstrCount=1.
- LW with a 3-cycle ack delay in MEM -> MemReq and SelEndMem=1 held 3 cycles; total 7 cycles; WB with MemToReg=1 and RegDest=1.
- BEQ with Zero=1 and again with Zero=0 -> EscPC=1 in EXEC only for Zero=1; Branch=1 in both; 3 cycles each.
- HALT after 255 retired instructions -> InstrCount wraps to 0; Halted=1; Start ignored.
- Reset_n=0 pulse while in MEM -> immediate IDLE and outputs 0; MemAck the next cycle is ignored.
- Watchdog on, MemAck held 0 in FETCH -> Erro=1 and Halted=1 after 15 wait cycles; watchdog off -> stays in FETCH.

Source files
------------

// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared opcodes, ULA codes, state encoding and watchdog limit for the nRISC sequencer
package nrisc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_LW   = 3'b010,
        OP_SW   = 3'b011,
        OP_BEQ  = 3'b100,
        OP_JR   = 3'b101,
        OP_MOVE = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;

    localparam logic [3:0] WD_LIMIT = 4'd15;

    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/nrisc_mem_hs.sv
// rtl/nrisc_mem_hs.sv - memory request/ack qualification with optional watchdog (NRISC_SEQ_WATCHDOG_EN)
module nrisc_mem_hs
    import nrisc_pkg::*;
(
`ifdef NRISC_SEQ_WATCHDOG_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req_i,
    input  logic ack_i,
    output logic mem_req_o,
    output logic done_o,
    output logic timeout_o
);

    // The request is owned by the sequencer state, so it cannot change until an ack is qualified.
    assign mem_req_o = req_i;
    // An ack only counts while a request is outstanding.
    assign done_o    = req_i & ack_i;

`ifdef NRISC_SEQ_WATCHDOG_EN
    logic [3:0] wd_q;
    logic [3:0] wd_d;
    logic       waiting;

    assign waiting = req_i & ~ack_i;

    // Count consecutive unanswered request cycles; fire on the one that reaches the limit.
    always_comb begin
        wd_d      = 4'd0;
        timeout_o = 1'b0;
        if (waiting) begin
            wd_d = wd_q + 4'd1;
            if (wd_d == WD_LIMIT) begin
                timeout_o = 1'b1;
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= 4'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/nrisc_seq_ctrl.sv
// rtl/nrisc_seq_ctrl.sv - multicycle nRISC control sequencer top (watchdog via NRISC_SEQ_WATCHDOG_EN)
module nrisc_seq_ctrl
    import nrisc_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [2:0] OpcodeIn,
    input  logic       Zero,
    input  logic       MemAck,
    output logic       MemReq,
    output logic       SelEndMem,
    output logic       LerMem,
    output logic       EscMem,
    output logic       EscIR,
    output logic       EscPC,
    output logic       Branch,
    output logic       Jump,
    output logic       EscReg,
    output logic       MemToReg,
    output logic       MoveReg,
    output logic       RegDest,
    output logic       ULAFonte,
    output logic [1:0] ULAOp,
    output logic       Busy,
    output logic       Halted,
    output logic       Erro,
    output logic [7:0] InstrCount
);

    state_e     state_q, state_d;
    opcode_e    opcode_q, opcode_d;
    logic [7:0] icount_q, icount_d;
    logic       halted_q, halted_d;
    logic       req, done, timeout;

    assign req = (state_q == ST_FETCH) || (state_q == ST_MEM);

    nrisc_mem_hs u_mem_hs (
`ifdef NRISC_SEQ_WATCHDOG_EN
        .clk       (Clock),
        .rst_n     (Reset_n),
`endif
        .req_i     (req),
        .ack_i     (MemAck),
        .mem_req_o (MemReq),
        .done_o    (done),
        .timeout_o (timeout)
    );

    // Next state, opcode latch, retire counter and per-state strobes.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        icount_d  = icount_q;
        SelEndMem = 1'b0;
        LerMem    = 1'b0;
        EscMem    = 1'b0;
        EscIR     = 1'b0;
        EscPC     = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        EscReg    = 1'b0;
        MemToReg  = 1'b0;
        MoveReg   = 1'b0;
        RegDest   = 1'b0;
        ULAFonte  = 1'b0;
        ULAOp     = ULA_ADD;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                LerMem = 1'b1;
                if (timeout) begin
                    state_d = ST_HALTED;
                end else if (done) begin
                    opcode_d = opcode_e'(OpcodeIn);
                    EscIR    = 1'b1;
                    EscPC    = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode_q == OP_HALT)      state_d = ST_HALTED;
                else if (opcode_q == OP_MOVE) state_d = ST_WB;
                else                          state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode_q)
                    OP_ADD:  begin ULAOp = ULA_ADD; state_d = ST_WB; end
                    OP_SUB:  begin ULAOp = ULA_SUB; state_d = ST_WB; end
                    OP_LW, OP_SW: begin
                        ULAFonte = 1'b1;
                        ULAOp    = ULA_ADD;
                        state_d  = ST_MEM;
                    end
                    OP_BEQ: begin
                        ULAOp   = ULA_SUB;
                        Branch  = 1'b1;
                        EscPC   = Zero;
                        state_d = ST_FETCH;
                    end
                    OP_JR: begin
                        Jump    = 1'b1;
                        EscPC   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                SelEndMem = 1'b1;
                LerMem    = (opcode_q == OP_LW);
                EscMem    = (opcode_q == OP_SW);
                if (timeout) begin
                    state_d = ST_HALTED;
                end else if (done) begin
                    state_d = (opcode_q == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                EscReg   = 1'b1;
                MemToReg = (opcode_q == OP_LW);
                RegDest  = (opcode_q == OP_LW);
                MoveReg  = (opcode_q == OP_MOVE);
                state_d  = ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        if ((state_d == ST_FETCH) && ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))) begin
            icount_d = icount_q + 8'd1;
        end else if ((state_d == ST_HALTED) && (state_q != ST_HALTED)) begin
            icount_d = icount_q + 8'd1;
        end
        halted_d = (state_d == ST_HALTED);
    end

    // Sequencer state and registered status.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_ADD;
            icount_q <= 8'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            icount_q <= icount_d;
            halted_q <= halted_d;
        end
    end

`ifdef NRISC_SEQ_WATCHDOG_EN
    logic erro_q, erro_d;

    assign erro_d = erro_q | timeout;

    // Sticky watchdog fault flag.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end

    assign Erro = erro_q;
`else
    assign Erro = 1'b0;
`endif

    assign Busy       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign Halted     = halted_q;
    assign InstrCount = icount_q;

endmodule
